demux_1to8_tdm: RTL and testbench
=================================

DEMUX_1TO8_TDM -- requirements
Module: demux_1to8_tdm

Interface
REQ-001 The block SHALL have these ports, one per line, in the form name, direction, width, meaning.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- din  input  4  serialized nibble from the 8:1 channel multiplexer.
- din_valid  input  1  din carries a nibble this cycle.
- frame_start  input  1  qualified by din_valid; marks the nibble for channel 1.
- y1..y8  output  4 each  committed per-channel nibbles, registered.
- sel  output  3  index (0-7) of the next expected channel slot.
- busy  output  1  high while a frame is partially received.
- frame_done  output  1  one-cycle pulse: a full frame was committed to y1..y8.
- frame_err  output  1  one-cycle pulse: a partial frame was aborted by a new frame_start.

Function
REQ-002 The block SHALL implement FSM states IDLE and RECV, with busy = (state == RECV).
REQ-003 The block SHALL hold eight 4-bit shadow registers and a 3-bit slot counter cnt, with sel = cnt.
REQ-004 In IDLE, on din_valid & frame_start, the block SHALL set shadow[0] = din and cnt = 1, and enter RECV.
REQ-005 In IDLE, the block SHALL ignore din_valid without frame_start, with no state or output change.
REQ-006 frame_start with din_valid low SHALL be ignored in every state.
REQ-007 In RECV, on din_valid & !frame_start with cnt < 7, the block SHALL set shadow[cnt] = din and increment cnt.
REQ-008 In RECV, on din_valid & !frame_start with cnt == 7, the block SHALL perform a commit on the same edge:
- y1..y7 = shadow[0..6] and y8 = din;
- frame_done = 1 for exactly one cycle;
- cnt = 0 and state = IDLE.
REQ-009 Latency SHALL be: new y values visible the cycle after the 8th nibble is accepted, coincident with frame_done.
REQ-010 y1..y8 SHALL update only on a commit, all eight in the same cycle; otherwise they hold the last committed frame.
REQ-011 In RECV, on din_valid & frame_start, the block SHALL perform an abort-and-restart on the same edge:
- frame_err = 1 for one cycle;
- discard the partial frame, leaving y unchanged;
- set shadow[0] = din and cnt = 1, staying in RECV.
REQ-012 In RECV with din_valid low, the block SHALL hold cnt, shadow and state indefinitely, with no timeout.
REQ-013 frame_start accepted the cycle immediately after a commit SHALL start a new frame normally, giving back-to-back frames with zero bubble.
REQ-014 frame_done and frame_err SHALL never be asserted in the same cycle.
REQ-015 cnt SHALL never wrap within a frame: the 8th accepted nibble always commits.

Reset
REQ-016 When rst is high at a clock edge, the block SHALL set:
- state = IDLE, cnt = 0, all shadow registers = 0;
- y1..y8 = 4'h0, sel = 0, busy = 0, frame_done = 0, frame_err = 0.
REQ-017 rst SHALL take priority over all other inputs in the same cycle.
REQ-018 A reset asserted mid-frame SHALL discard the partial frame, with no frame_done or frame_err pulse.
REQ-019 The first valid nibble after reset release SHALL be accepted only with frame_start.

Verification
REQ-020 The verification bench SHALL cover these directed scenarios:
- Basic frame: 8 consecutive valid nibbles 1..8, frame_start on the first -> next cycle y1..y8 = 1..8, frame_done pulse, busy 0, sel 0.
- Gapped frame: nibbles A..H with din_valid low for 3 cycles after the 4th -> y unchanged and sel = 4 during the gap; after H, y1..y8 = A..H.
- Abort: start frame with F,E,D, then frame_start with 5 and seven more nibbles 6..C -> frame_err pulse at the restart; y unchanged until commit; final y1..y8 = 5,6,7,8,9,A,B,C.
- Back-to-back: two frames (1..8, then 8..1) with no idle cycle -> two frame_done pulses 8 cycles apart; final y1..y8 = 8..1.
- Reset mid-frame: rst after 5 nibbles of a frame following a committed frame of all 3s -> y1..y8 = 0, no pulses; later nibbles without frame_start ignored.
- Stray data: din_valid nibbles without frame_start in IDLE -> busy 0, y unchanged, no pulses.

Source files
------------

// File: rtl/demux_1to8_tdm.sv
// 1:8 time-division demultiplexer: collects eight serialized nibbles per
// frame into shadow storage and commits them to y1..y8 in one cycle.
module demux_1to8_tdm (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] din,
    input  logic       din_valid,
    input  logic       frame_start,
    output logic [3:0] y1,
    output logic [3:0] y2,
    output logic [3:0] y3,
    output logic [3:0] y4,
    output logic [3:0] y5,
    output logic [3:0] y6,
    output logic [3:0] y7,
    output logic [3:0] y8,
    output logic [2:0] sel,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_err
);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic [2:0] cnt_next;
    logic [3:0] shadow [8];

    logic       load_first;
    logic       store;
    logic       commit;
    logic       restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load_first = 1'b0;
        store      = 1'b0;
        commit     = 1'b0;
        restart    = 1'b0;
        unique case (state)
            IDLE: begin
                // data without frame_start is stray and dropped here
                if (din_valid && frame_start) begin
                    load_first = 1'b1;
                    cnt_next   = 3'd1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (din_valid) begin
                    if (frame_start) begin
                        restart    = 1'b1;
                        load_first = 1'b1;
                        cnt_next   = 3'd1;
                    end else if (cnt == 3'd7) begin
                        commit     = 1'b1;
                        cnt_next   = 3'd0;
                        state_next = IDLE;
                    end else begin
                        store    = 1'b1;
                        cnt_next = cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 4'h0;
            end
        end else if (load_first) begin
            shadow[0] <= din;
        end else if (store) begin
            shadow[cnt] <= din;
        end
    end

    // the eighth nibble bypasses shadow so the commit lands on its own edge
    always_ff @(posedge clk) begin
        if (rst) begin
            y1 <= 4'h0;
            y2 <= 4'h0;
            y3 <= 4'h0;
            y4 <= 4'h0;
            y5 <= 4'h0;
            y6 <= 4'h0;
            y7 <= 4'h0;
            y8 <= 4'h0;
        end else if (commit) begin
            y1 <= shadow[0];
            y2 <= shadow[1];
            y3 <= shadow[2];
            y4 <= shadow[3];
            y5 <= shadow[4];
            y6 <= shadow[5];
            y7 <= shadow[6];
            y8 <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= commit;
            frame_err  <= restart;
        end
    end

    assign sel  = cnt;
    assign busy = (state == RECV);

endmodule

// File: tb/tb_demux_1to8_tdm.sv
// Directed bench for demux_1to8_tdm: a queue-based frame model checked
// every cycle, plus literal expectations for each scenario.
module tb_demux_1to8_tdm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din;
    logic       din_valid;
    logic       frame_start;
    logic [3:0] y1, y2, y3, y4, y5, y6, y7, y8;
    logic [2:0] sel;
    logic       busy;
    logic       frame_done;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    demux_1to8_tdm dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_start(frame_start),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .y4         (y4),
        .y5         (y5),
        .y6         (y6),
        .y7         (y7),
        .y8         (y8),
        .sel        (sel),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // model: a frame is the list of nibbles received since its frame_start
    logic [3:0] q [$];
    logic [3:0] my [8];
    logic       m_done;
    logic       m_err;
    logic       started = 1'b0;

    always @(posedge clk) begin
        m_done = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            q.delete();
            for (int i = 0; i < 8; i++) my[i] = 4'h0;
            started = 1'b1;
        end else if (din_valid) begin
            if (frame_start) begin
                if (q.size() != 0) m_err = 1'b1;
                q.delete();
                q.push_back(din);
            end else if (q.size() != 0) begin
                q.push_back(din);
                if (q.size() == 8) begin
                    for (int i = 0; i < 8; i++) my[i] = q[i];
                    q.delete();
                    m_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [37:0] act;
        logic [37:0] exp;
        if (started) begin
            act = {y1, y2, y3, y4, y5, y6, y7, y8,
                   sel, busy, frame_done, frame_err};
            exp = {my[0], my[1], my[2], my[3], my[4], my[5], my[6], my[7],
                   3'(q.size()), q.size() != 0, m_done, m_err};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model t=%0t got y=%h sel=%0d b/d/e=%b need y=%h sel=%0d b/d/e=%b",
                         $time, act[37:6], act[5:3], act[2:0],
                         exp[37:6], exp[5:3], exp[2:0]);
            end
        end
    end

    task automatic cyc(input logic r, input logic v,
                       input logic fs, input logic [3:0] d);
        rst         = r;
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h need %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] yv();
        return {y1, y2, y3, y4, y5, y6, y7, y8};
    endfunction

    function automatic logic [31:0] flags();
        return {26'd0, sel, busy, frame_done, frame_err};
    endfunction

    int done_at [$];

    initial begin
        logic [31:0] pat;
        rst = 1'b1; din_valid = 1'b0; frame_start = 1'b0; din = 4'h0;
        cyc(1, 1, 1, 4'h9);
        chk("reset_y", yv(), 32'h0);
        chk("reset_flags", flags(), 32'h0);

        // basic frame 1..8
        cyc(0, 1, 1, 4'h1);
        chk("basic_sel1", flags(), {26'd0, 3'd1, 3'b100});
        for (int i = 2; i <= 8; i++) cyc(0, 1, 0, 4'(i));
        chk("basic_y", yv(), 32'h12345678);
        chk("basic_flags", flags(), {26'd0, 3'd0, 3'b010});
        cyc(0, 0, 0, 4'h0);
        chk("basic_done_clr", flags(), 32'h0);

        // gapped frame, with a lone frame_start during the gap
        pat = 32'hABCDEF01;
        cyc(0, 1, 1, pat[31:28]);
        for (int i = 1; i < 4; i++) cyc(0, 1, 0, pat[31-4*i -: 4]);
        cyc(0, 0, 0, 4'h0);
        cyc(0, 0, 1, 4'h7);
        cyc(0, 0, 0, 4'h0);
        chk("gap_sel", flags(), {26'd0, 3'd4, 3'b100});
        chk("gap_y", yv(), 32'h12345678);
        for (int i = 4; i < 8; i++) cyc(0, 1, 0, pat[31-4*i -: 4]);
        chk("gap_final", yv(), 32'hABCDEF01);

        // abort and restart
        cyc(0, 1, 1, 4'hF);
        cyc(0, 1, 0, 4'hE);
        cyc(0, 1, 0, 4'hD);
        cyc(0, 1, 1, 4'h5);
        chk("abort_flags", flags(), {26'd0, 3'd1, 3'b101});
        chk("abort_y", yv(), 32'hABCDEF01);
        for (int i = 6; i <= 12; i++) cyc(0, 1, 0, 4'(i));
        chk("abort_final", yv(), 32'h56789ABC);

        // back-to-back frames with no idle cycle
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, (i % 8) == 0, (i < 8) ? 4'(i + 1) : 4'(16 - i));
            if (frame_done) done_at.push_back(i);
        end
        checks++;
        if (done_at.size() != 2 || done_at[0] != 7 || done_at[1] != 15) begin
            errors++;
            $display("FAIL b2b_done got %0d pulses need 2 at 7,15",
                     done_at.size());
        end
        chk("b2b_y", yv(), 32'h87654321);

        // stray data in idle
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'hC);
        chk("stray_y", yv(), 32'h87654321);
        chk("stray_flags", flags(), 32'h0);

        // reset mid-frame after an all-3 frame
        cyc(0, 1, 1, 4'h3);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 4'h3);
        chk("threes_y", yv(), 32'h33333333);
        cyc(0, 1, 1, 4'h4);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 4'h4);
        cyc(1, 1, 1, 4'h6);
        chk("rst_y", yv(), 32'h0);
        chk("rst_flags", flags(), 32'h0);
        cyc(0, 0, 0, 4'h0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 4'h4);
        chk("post_rst_y", yv(), 32'h0);
        chk("post_rst_flags", flags(), 32'h0);

        cyc(0, 0, 0, 4'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
